// File: rtl/mem_write_checker.sv
// Pass/fail monitor: compares data-memory writes against NSIG (addr,data) signatures, with a cycle timeout.
// Latency: a qualifying write shows on pass/pass_idx/match_cnt after one clk edge; all outputs come from registers.
// Backpressure: none; the block only observes the write bus and never stalls the core.

module mem_write_checker #(
  parameter int DW      = 64,
  parameter int AW      = 64,
  parameter int NSIG    = 4,
  parameter int CNTW    = 16,
  parameter int ORDERED = 0,
  localparam int IW     = (NSIG > 1) ? $clog2(NSIG) : 1,
  localparam int MW     = $clog2(NSIG + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic [1:0]           i_memwrite,
  input  logic [AW-1:0]        i_dataadr,
  input  logic [DW-1:0]        i_writedata,
  input  logic [NSIG*AW-1:0]   i_sig_addr,
  input  logic [NSIG*DW-1:0]   i_sig_data,
  input  logic [NSIG-1:0]      i_sig_en,
  input  logic [CNTW-1:0]      i_timeout_lim,
  output logic                 o_done,
  output logic                 o_pass,
  output logic                 o_timeout,
  output logic [IW-1:0]        o_pass_idx,
  output logic [MW-1:0]        o_match_cnt,
  output logic [CNTW-1:0]      o_cycle_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PASS    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [CNTW-1:0]   r_cycle_cnt;
  logic [MW-1:0]     r_match_cnt;
  logic [IW-1:0]     r_pass_idx;
  // Ordered-mode search start; can reach NSIG once the last entry is consumed.
  logic [MW-1:0]     r_ptr;

  logic              w_write;
  logic [NSIG-1:0]   w_hit;
  logic              w_any_hit;
  logic [IW-1:0]     w_low_hit;
  logic              w_cur_vld;
  logic [IW-1:0]     w_cur;
  logic              w_more;
  logic              w_ord_hit;
  logic              w_complete;
  logic [IW-1:0]     w_done_idx;
  logic              w_lim_hit;

  assign w_write = |i_memwrite;

  // Per-entry full-width address/data match, gated by the write strobe and entry enable.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NSIG; i++) begin
      w_hit[i] = w_write & i_sig_en[i]
               & (i_dataadr   == i_sig_addr[i*AW +: AW])
               & (i_writedata == i_sig_data[i*DW +: DW]);
    end
  end

  // Lowest-index hit, used when any single match is enough.
  always_comb begin
    w_any_hit = 1'b0;
    w_low_hit = '0;
    for (int i = NSIG - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_any_hit = 1'b1;
        w_low_hit = IW'(i);
      end
    end
  end

  // Effective ordered pointer: lowest enabled entry at or above r_ptr, and whether any enabled entry follows it.
  // Enables are live, so this only ever moves forward from r_ptr and never looks back.
  always_comb begin
    w_cur_vld = 1'b0;
    w_cur     = '0;
    w_more    = 1'b0;
    for (int i = NSIG - 1; i >= 0; i--) begin
      if (i_sig_en[i] && (MW'(i) >= r_ptr)) begin
        w_cur_vld = 1'b1;
        w_cur     = IW'(i);
      end
    end
    for (int i = 0; i < NSIG; i++) begin
      if (w_cur_vld && i_sig_en[i] && (IW'(i) > w_cur)) begin
        w_more = 1'b1;
      end
    end
  end

  assign w_ord_hit  = w_cur_vld & w_hit[w_cur];
  assign w_complete = (ORDERED != 0) ? (w_ord_hit & ~w_more) : w_any_hit;
  assign w_done_idx = (ORDERED != 0) ? w_cur : w_low_hit;

  // Timeout fires on the last allowed RUN cycle; a limit of zero disables it.
  assign w_lim_hit  = (i_timeout_lim != '0) && (r_cycle_cnt == (i_timeout_lim - CNTW'(1)));

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: enable low always aborts to IDLE; completion beats timeout in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_enable) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!i_enable)       w_state_nxt = S_IDLE;
        else if (w_complete) w_state_nxt = S_PASS;
        else if (w_lim_hit)  w_state_nxt = S_TIMEOUT;
      end
      S_PASS, S_TIMEOUT: begin
        if (!i_enable) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Counters and match bookkeeping: cleared on RUN entry, advanced only in RUN, held everywhere else.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cycle_cnt <= '0;
      r_match_cnt <= '0;
      r_pass_idx  <= '0;
      r_ptr       <= '0;
    end else if ((r_state == S_IDLE) && i_enable) begin
      r_cycle_cnt <= '0;
      r_match_cnt <= '0;
      r_pass_idx  <= '0;
      r_ptr       <= '0;
    end else if ((r_state == S_RUN) && i_enable) begin
      if (r_cycle_cnt != {CNTW{1'b1}}) begin
        r_cycle_cnt <= r_cycle_cnt + CNTW'(1);
      end
      if (ORDERED != 0) begin
        if (w_ord_hit) begin
          r_match_cnt <= r_match_cnt + MW'(1);
          r_ptr       <= MW'(w_cur) + MW'(1);
          if (!w_more) r_pass_idx <= w_done_idx;
        end
      end else if (w_any_hit) begin
        r_match_cnt <= MW'(1);
        r_pass_idx  <= w_done_idx;
      end
    end
  end

  assign o_pass      = (r_state == S_PASS);
  assign o_timeout   = (r_state == S_TIMEOUT);
  assign o_done      = o_pass | o_timeout;
  assign o_pass_idx  = r_pass_idx;
  assign o_match_cnt = r_match_cnt;
  assign o_cycle_cnt = r_cycle_cnt;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: one instance per mode, driven by shared stimulus.
// Latency: inputs change 1 time unit after a rising edge and outputs are sampled at the same point.
// Backpressure: not applicable; the bench only drives writes and observes results.

module tb_mem_write_checker;

  logic         clk;
  logic         reset;
  logic         enable;
  logic [1:0]   memwrite;
  logic [63:0]  dataadr;
  logic [63:0]  writedata;
  logic [255:0] sig_addr;
  logic [255:0] sig_data;
  logic [3:0]   sig_en;
  logic [15:0]  timeout_lim;

  logic         a_done, a_pass, a_timeout;
  logic [1:0]   a_idx;
  logic [2:0]   a_match;
  logic [15:0]  a_cnt;
  logic         o_done, o_pass, o_timeout;
  logic [1:0]   o_idx;
  logic [2:0]   o_match;
  logic [15:0]  o_cnt;

  int           n_tests;
  int           n_fail;
  logic [47:0]  got;
  logic [47:0]  exp;

  mem_write_checker #(.DW(64), .AW(64), .NSIG(4), .CNTW(16), .ORDERED(0)) u_any (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_memwrite(memwrite),
    .i_dataadr(dataadr), .i_writedata(writedata), .i_sig_addr(sig_addr),
    .i_sig_data(sig_data), .i_sig_en(sig_en), .i_timeout_lim(timeout_lim),
    .o_done(a_done), .o_pass(a_pass), .o_timeout(a_timeout),
    .o_pass_idx(a_idx), .o_match_cnt(a_match), .o_cycle_cnt(a_cnt)
  );

  mem_write_checker #(.DW(64), .AW(64), .NSIG(4), .CNTW(16), .ORDERED(1)) u_ord (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_memwrite(memwrite),
    .i_dataadr(dataadr), .i_writedata(writedata), .i_sig_addr(sig_addr),
    .i_sig_data(sig_data), .i_sig_en(sig_en), .i_timeout_lim(timeout_lim),
    .o_done(o_done), .o_pass(o_pass), .o_timeout(o_timeout),
    .o_pass_idx(o_idx), .o_match_cnt(o_match), .o_cycle_cnt(o_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cfg();
    sig_addr    = '0;
    sig_data    = '0;
    sig_en      = '0;
    timeout_lim = '0;
    memwrite    = 2'b00;
    dataadr     = '0;
    writedata   = '0;
  endtask

  task automatic set_sig(input int i, input logic [63:0] a, input logic [63:0] d);
    sig_addr[i*64 +: 64] = a;
    sig_data[i*64 +: 64] = d;
  endtask

  task automatic wr(input logic [63:0] a, input logic [63:0] d);
    memwrite  = 2'b01;
    dataadr   = a;
    writedata = d;
  endtask

  task automatic start_run();
    enable = 1'b1;
    tick();
  endtask

  task automatic go_idle();
    memwrite = 2'b00;
    enable   = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    got = {a_done, a_pass, a_timeout, a_idx, a_match, a_cnt, o_done, o_pass, o_timeout, o_idx, o_match, o_cnt};
    exp = '0;
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_outputs: got %h want %h", got, exp); end
    reset = 1'b0;
    tick();
    got = {a_done, a_cnt, o_done, o_cnt};
    exp = '0;
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL idle_after_reset: got %h want %h", got, exp); end
  endtask

  task automatic test_single_match();
    clear_cfg();
    set_sig(0, 64'd84, 64'd7);
    set_sig(1, 64'd128, 64'd7);
    set_sig(2, 64'd80, 64'd1);
    sig_en = 4'b0111;
    timeout_lim = 16'd16;
    start_run();
    repeat (5) tick();
    got = {a_pass, a_done, a_cnt};
    exp = {1'b0, 1'b0, 16'd5};
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL run_count: got %h want %h", got, exp); end
    wr(64'd128, 64'd7);
    tick();
    got = {a_pass, a_done, a_timeout, a_idx, a_match, a_cnt};
    exp = {1'b1, 1'b1, 1'b0, 2'd1, 3'd1, 16'd6};
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL single_match: got %h want %h", got, exp); end
    wr(64'd84, 64'd7);
    tick();
    memwrite = 2'b00;
    repeat (3) tick();
    got = {a_pass, a_done, a_timeout, a_idx, a_match, a_cnt};
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL pass_sticky: got %h want %h", got, exp); end
    go_idle();
  endtask

  task automatic test_timeout();
    start_run();
    for (int k = 0; k < 15; k++) begin
      if (k % 2 == 0) wr(64'd84, 64'd6);
      else            wr(64'd85, 64'd7);
      tick();
    end
    got = {a_timeout, a_pass, a_cnt};
    exp = {1'b0, 1'b0, 16'd15};
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL timeout_early: got %h want %h", got, exp); end
    tick();
    got = {a_timeout, a_pass, a_done, a_cnt};
    exp = {1'b1, 1'b0, 1'b1, 16'd16};
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL timeout_fire: got %h want %h", got, exp); end
    memwrite = 2'b00;
    repeat (3) tick();
    n_tests++;
    if ({a_timeout, a_pass, a_done, a_cnt} !== exp) begin
      n_fail++; $display("FAIL timeout_sticky: got %h want %h", {a_timeout, a_pass, a_done, a_cnt}, exp);
    end
    go_idle();
    got = {a_timeout, a_done, a_cnt};
    exp = {1'b0, 1'b0, 16'd16};
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL idle_hold_cnt: got %h want %h", got, exp); end
  endtask

  task automatic test_ordered();
    clear_cfg();
    set_sig(0, 64'd80, 64'd1);
    set_sig(1, 64'd84, 64'd7);
    sig_en = 4'b0011;
    start_run();
    wr(64'd84, 64'd7);
    tick();
    got = {o_pass, o_match, a_pass, a_idx};
    exp = {1'b0, 3'd0, 1'b1, 2'd1};
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL ord_out_of_order: got %h want %h", got, exp); end
    wr(64'd80, 64'd1);
    tick();
    memwrite = 2'b00;
    tick();
    got = {o_pass, o_match};
    exp = {1'b0, 3'd1};
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL ord_first: got %h want %h", got, exp); end
    wr(64'd84, 64'd7);
    tick();
    got = {o_pass, o_done, o_idx, o_match, o_cnt};
    exp = {1'b1, 1'b1, 2'd1, 3'd2, 16'd4};
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL ord_complete: got %h want %h", got, exp); end
    wr(64'd80, 64'd1);
    tick();
    n_tests++;
    if ({o_pass, o_done, o_idx, o_match, o_cnt} !== exp) begin
      n_fail++; $display("FAIL ord_sticky: got %h want %h", {o_pass, o_done, o_idx, o_match, o_cnt}, exp);
    end
    go_idle();
  endtask

  task automatic test_ordered_skip();
    clear_cfg();
    set_sig(0, 64'd80, 64'd1);
    set_sig(1, 64'd84, 64'd7);
    set_sig(2, 64'd88, 64'd3);
    sig_en = 4'b0101;
    start_run();
    wr(64'd88, 64'd3);
    tick();
    wr(64'd80, 64'd1);
    tick();
    wr(64'd84, 64'd7);
    tick();
    got = {o_pass, o_match};
    exp = {1'b0, 3'd1};
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL ord_skip_partial: got %h want %h", got, exp); end
    wr(64'd88, 64'd3);
    tick();
    got = {o_pass, o_idx, o_match};
    exp = {1'b1, 2'd2, 3'd2};
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL ord_skip_complete: got %h want %h", got, exp); end
    go_idle();
  endtask

  task automatic test_priority();
    clear_cfg();
    set_sig(0, 64'd84, 64'd7);
    set_sig(1, 64'd84, 64'd7);
    set_sig(3, 64'd84, 64'd7);
    sig_en = 4'b1010;
    start_run();
    dataadr   = 64'd84;
    writedata = 64'd7;
    memwrite  = 2'b00;
    tick();
    got = {a_pass, a_done};
    exp = '0;
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL no_strobe: got %h want %h", got, exp); end
    memwrite = 2'b10;
    tick();
    got = {a_pass, a_idx, a_match, a_cnt};
    exp = {1'b1, 2'd1, 3'd1, 16'd2};
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL lowest_hit: got %h want %h", got, exp); end
    go_idle();
  endtask

  task automatic test_lim_edge();
    clear_cfg();
    set_sig(2, 64'd80, 64'd1);
    sig_en = 4'b0100;
    timeout_lim = 16'd4;
    start_run();
    repeat (3) tick();
    wr(64'd80, 64'd1);
    tick();
    got = {a_pass, a_timeout, a_cnt, o_pass, o_timeout, o_idx, o_match};
    exp = {1'b1, 1'b0, 16'd4, 1'b1, 1'b0, 2'd2, 3'd1};
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL pass_beats_timeout: got %h want %h", got, exp); end
    go_idle();
  endtask

  task automatic test_enable_drop();
    clear_cfg();
    set_sig(1, 64'd84, 64'd7);
    sig_en = 4'b0010;
    start_run();
    repeat (2) tick();
    wr(64'd84, 64'd7);
    tick();
    memwrite = 2'b00;
    enable = 1'b0;
    tick();
    got = {a_pass, a_done, a_idx, a_match, a_cnt};
    exp = {1'b0, 1'b0, 2'd1, 3'd1, 16'd3};
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL drop_enable_hold: got %h want %h", got, exp); end
    enable = 1'b1;
    tick();
    got = {a_pass, a_done, a_idx, a_match, a_cnt};
    exp = '0;
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL rerun_clear: got %h want %h", got, exp); end
    go_idle();
  endtask

  task automatic test_reset_midrun();
    clear_cfg();
    set_sig(0, 64'd80, 64'd1);
    set_sig(1, 64'd84, 64'd7);
    sig_en = 4'b0011;
    start_run();
    wr(64'd80, 64'd1);
    tick();
    memwrite = 2'b00;
    repeat (6) tick();
    got = {o_cnt, o_match, a_pass};
    exp = {16'd7, 3'd1, 1'b1};
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL pre_reset: got %h want %h", got, exp); end
    reset = 1'b1;
    #1;
    got = {a_done, a_pass, a_timeout, a_idx, a_match, a_cnt, o_done, o_pass, o_timeout, o_idx, o_match, o_cnt};
    exp = '0;
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL async_reset: got %h want %h", got, exp); end
    enable = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    enable = 1'b1;
    repeat (2) tick();
    got = {o_done, o_cnt};
    exp = {1'b0, 16'd1};
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL restart_after_reset: got %h want %h", got, exp); end
    go_idle();
  endtask

  task automatic test_saturate();
    clear_cfg();
    set_sig(0, 64'd80, 64'd1);
    wr(64'd80, 64'd1);
    start_run();
    repeat (65534) tick();
    got = {a_cnt, o_cnt};
    exp = {16'd65534, 16'd65534};
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL count_before_sat: got %h want %h", got, exp); end
    tick();
    got = {a_cnt, o_cnt};
    exp = {16'hFFFF, 16'hFFFF};
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL count_at_sat: got %h want %h", got, exp); end
    repeat (70000 - 65535) tick();
    got = {a_done, a_cnt, o_done, o_cnt};
    exp = {1'b0, 16'hFFFF, 1'b0, 16'hFFFF};
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL sat_hold_no_done: got %h want %h", got, exp); end
    go_idle();
  endtask

  initial begin
    clk     = 1'b0;
    reset   = 1'b1;
    enable  = 1'b0;
    n_tests = 0;
    n_fail  = 0;
    clear_cfg();
    test_reset();
    test_single_match();
    test_timeout();
    test_ordered();
    test_ordered_skip();
    test_priority();
    test_lim_edge();
    test_enable_drop();
    test_reset_midrun();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
